// File: rtl/step_counter_pkg.sv
// Shared defaults and helpers for the step counter family.
package step_counter_pkg;

  localparam int D_WIDTH    = 10;
  localparam int D_RST_VAL  = -50;
  localparam int D_UP_STEP  = 5;
  localparam int D_DN_STEP  = 9;
  localparam int D_MAX_VAL  = 230;
  localparam int D_MIN_VAL  = -230;
  localparam int D_SKIP_VAL = -11;
  localparam int D_WRAP     = 0;

  // Clamp a signed value into [lo, hi]; shared by the load and count paths.
  function automatic int clamp_val(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/step_counter_next.sv
// Combinational next-value and status-flag calculator for step_counter.
// Evaluates both the load path and the count path; the parent decides
// whether the result is used (load or en) or the register simply holds.
module step_counter_next
  import step_counter_pkg::*;
#(
  parameter int WIDTH    = D_WIDTH,
  parameter int UP_STEP  = D_UP_STEP,
  parameter int DN_STEP  = D_DN_STEP,
  parameter int MAX_VAL  = D_MAX_VAL,
  parameter int MIN_VAL  = D_MIN_VAL,
  parameter int SKIP_VAL = D_SKIP_VAL,
  parameter int WRAP     = D_WRAP
) (
  input  logic signed [WIDTH-1:0] cnt_i,
  input  logic                    mode_i,
  input  logic                    load_i,
  input  logic signed [WIDTH-1:0] load_val_i,
  output logic signed [WIDTH-1:0] next_o,
  output logic                    skipped_o,
  output logic                    limited_o,
  output logic                    load_err_o
);

  // Two guard bits so cnt +/- 2*step can never overflow before the limit test.
  localparam logic signed [WIDTH+1:0] UP_X   = (WIDTH+2)'(UP_STEP);
  localparam logic signed [WIDTH+1:0] DN_X   = (WIDTH+2)'(DN_STEP);
  localparam logic signed [WIDTH+1:0] SKIP_X = (WIDTH+2)'(SKIP_VAL);
  localparam logic signed [WIDTH-1:0] SKIP_W = WIDTH'(SKIP_VAL);
  localparam logic signed [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic signed [WIDTH-1:0] MIN_W  = WIDTH'(MIN_VAL);

  logic signed [WIDTH+1:0] cnt_x;
  logic signed [WIDTH+1:0] step_x;
  logic signed [WIDTH+1:0] n_x;
  int                      n_int;
  int                      n_clamped;
  int                      ld_int;
  int                      ld_clamped;

  assign cnt_x  = {{2{cnt_i[WIDTH-1]}}, cnt_i};
  assign step_x = mode_i ? UP_X : -DN_X;

  // Next value: load path clamps/rejects, count path skips then limits.
  always_comb begin
    next_o     = cnt_i;
    skipped_o  = 1'b0;
    limited_o  = 1'b0;
    load_err_o = 1'b0;
    n_x        = cnt_x + step_x;
    n_int      = 0;
    n_clamped  = 0;
    ld_int     = int'(load_val_i);
    ld_clamped = clamp_val(ld_int, MIN_VAL, MAX_VAL);
    if (load_i) begin
      if (load_val_i == SKIP_W) begin
        // Loading the forbidden value is refused outright; cnt keeps its value.
        load_err_o = 1'b1;
      end else begin
        next_o     = WIDTH'(ld_clamped);
        load_err_o = (ld_clamped != ld_int);
      end
    end else begin
      // The skip is resolved first so a double step may still hit a limit.
      if (n_x == SKIP_X) begin
        n_x       = n_x + step_x;
        skipped_o = 1'b1;
      end
      n_int     = int'(n_x);
      n_clamped = clamp_val(n_int, MIN_VAL, MAX_VAL);
      limited_o = (n_clamped != n_int);
      if (limited_o && (WRAP != 0)) begin
        next_o = (n_int > MAX_VAL) ? MIN_W : MAX_W;
      end else begin
        next_o = WIDTH'(n_clamped);
      end
    end
  end

endmodule

// File: rtl/step_counter.sv
// Signed up/down step counter with limits, a stepped-over value, load and
// one-cycle status pulses. Holds only the registers and the reset/enable mux.
module step_counter
  import step_counter_pkg::*;
#(
  parameter int WIDTH    = D_WIDTH,
  parameter int RST_VAL  = D_RST_VAL,
  parameter int UP_STEP  = D_UP_STEP,
  parameter int DN_STEP  = D_DN_STEP,
  parameter int MAX_VAL  = D_MAX_VAL,
  parameter int MIN_VAL  = D_MIN_VAL,
  parameter int SKIP_VAL = D_SKIP_VAL,
  parameter int WRAP     = D_WRAP
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic                    load,
  input  logic signed [WIDTH-1:0] load_val,
  output logic signed [WIDTH-1:0] cnt,
  output logic                    at_max,
  output logic                    at_min,
  output logic                    skipped,
  output logic                    limited,
  output logic                    load_err
);

  localparam int REP_MAX = (1 <<< (WIDTH - 1)) - 1;
  localparam int REP_MIN = -(1 <<< (WIDTH - 1));
  localparam int STEP_LIM = 1 <<< (WIDTH - 2);
  localparam logic signed [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
  localparam logic signed [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic signed [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);

  // Parameter sanity: bad configurations stop elaboration.
  if (WIDTH < 3 || WIDTH > 30) begin : g_bad_width
    $fatal(1, "step_counter: WIDTH out of range");
  end
  if (!(MIN_VAL < RST_VAL && RST_VAL <= MAX_VAL)) begin : g_bad_rst
    $fatal(1, "step_counter: RST_VAL outside (MIN_VAL, MAX_VAL]");
  end
  if (MIN_VAL < REP_MIN || MAX_VAL > REP_MAX) begin : g_bad_lim
    $fatal(1, "step_counter: limits not representable");
  end
  if (!(SKIP_VAL > MIN_VAL && SKIP_VAL < MAX_VAL) || SKIP_VAL == RST_VAL) begin : g_bad_skip
    $fatal(1, "step_counter: SKIP_VAL misplaced");
  end
  if (UP_STEP < 1 || UP_STEP > STEP_LIM || DN_STEP < 1 || DN_STEP > STEP_LIM) begin : g_bad_step
    $fatal(1, "step_counter: step out of range");
  end
  if (SKIP_VAL + UP_STEP > REP_MAX || SKIP_VAL - UP_STEP < REP_MIN ||
      SKIP_VAL + DN_STEP > REP_MAX || SKIP_VAL - DN_STEP < REP_MIN) begin : g_bad_rep
    $fatal(1, "step_counter: SKIP_VAL +/- step not representable");
  end

  logic signed [WIDTH-1:0] cnt_q, cnt_d, next_val;
  logic skipped_q, skipped_d, limited_q, limited_d, load_err_q, load_err_d;
  logic nx_skipped, nx_limited, nx_load_err;

  step_counter_next #(
    .WIDTH(WIDTH), .UP_STEP(UP_STEP), .DN_STEP(DN_STEP), .MAX_VAL(MAX_VAL),
    .MIN_VAL(MIN_VAL), .SKIP_VAL(SKIP_VAL), .WRAP(WRAP)
  ) u_next (
    .cnt_i      (cnt_q),
    .mode_i     (mode),
    .load_i     (load),
    .load_val_i (load_val),
    .next_o     (next_val),
    .skipped_o  (nx_skipped),
    .limited_o  (nx_limited),
    .load_err_o (nx_load_err)
  );

  // Take the calculated update on load or enable; otherwise hold with no pulses.
  always_comb begin
    cnt_d      = cnt_q;
    skipped_d  = 1'b0;
    limited_d  = 1'b0;
    load_err_d = 1'b0;
    if (load || en) begin
      cnt_d      = next_val;
      skipped_d  = nx_skipped;
      limited_d  = nx_limited;
      load_err_d = nx_load_err;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= RST_W;
      skipped_q  <= 1'b0;
      limited_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      skipped_q  <= skipped_d;
      limited_q  <= limited_d;
      load_err_q <= load_err_d;
    end
  end

  assign cnt      = cnt_q;
  assign at_max   = (cnt_q == MAX_W);
  assign at_min   = (cnt_q == MIN_W);
  assign skipped  = skipped_q;
  assign limited  = limited_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_step_counter.sv
// Scoreboard bench for step_counter: a saturating and a wrapping instance
// share stimulus; an integer reference model predicts each update.
module tb_step_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic mode = 1'b0;
  logic load = 1'b0;
  logic signed [9:0] load_val = '0;

  logic signed [9:0] cnt0, cnt1;
  logic amax0, amin0, sk0, li0, le0;
  logic amax1, amin1, sk1, li1, le1;

  always #5 clk = ~clk;

  step_counter #(.WRAP(0)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .cnt(cnt0), .at_max(amax0), .at_min(amin0), .skipped(sk0), .limited(li0), .load_err(le0)
  );

  step_counter #(.WRAP(1)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
    .cnt(cnt1), .at_max(amax1), .at_min(amin1), .skipped(sk1), .limited(li1), .load_err(le1)
  );

  typedef struct {
    int cnt;
    bit sk;
    bit li;
    bit le;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int model0 = -50;
  int model1 = -50;
  int total = 0;
  int bad = 0;
  int txn = 0;

  // Reference behaviour from the counter's rules, in plain integers.
  function automatic exp_t ref_next(input int cur, input bit wrap, input bit r,
                                    input bit ld, input int lv, input bit e, input bit m);
    exp_t o;
    int n;
    int step;
    o.cnt = cur; o.sk = 0; o.li = 0; o.le = 0;
    step = m ? 5 : -9;
    if (!r) begin
      o.cnt = -50;
    end else if (ld) begin
      if (lv == -11) o.le = 1;
      else if (lv > 230) begin o.cnt = 230; o.le = 1; end
      else if (lv < -230) begin o.cnt = -230; o.le = 1; end
      else o.cnt = lv;
    end else if (e) begin
      n = cur + step;
      if (n == -11) begin n = n + step; o.sk = 1; end
      if (n > 230) begin o.cnt = wrap ? -230 : 230; o.li = 1; end
      else if (n < -230) begin o.cnt = wrap ? 230 : -230; o.li = 1; end
      else o.cnt = n;
    end
    return o;
  endfunction

  task automatic drive(input bit r, input bit ld, input int lv, input bit e, input bit m);
    exp_t x0, x1;
    @(negedge clk);
    rst = r; load = ld; load_val = 10'(lv); en = e; mode = m;
    x0 = ref_next(model0, 1'b0, r, ld, lv, e, m);
    x1 = ref_next(model1, 1'b1, r, ld, lv, e, m);
    model0 = x0.cnt;
    model1 = x1.cnt;
    q0.push_back(x0);
    q1.push_back(x1);
  endtask

  task automatic chk(input string tag, input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s.%s: got %0d want %0d", tag, name, act, want);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t x, input int c, input bit amx,
                         input bit amn, input bit s, input bit l, input bit le);
    $display("txn %0d %s cnt=%0d exp=%0d sk=%0b li=%0b le=%0b", txn, tag, c, x.cnt, s, l, le);
    chk(tag, "cnt", c, x.cnt);
    chk(tag, "at_max", int'(amx), int'(x.cnt == 230));
    chk(tag, "at_min", int'(amn), int'(x.cnt == -230));
    chk(tag, "skipped", int'(s), int'(x.sk));
    chk(tag, "limited", int'(l), int'(x.li));
    chk(tag, "load_err", int'(le), int'(x.le));
  endtask

  // Monitor: every edge produces an update, compared just after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        x = q0.pop_front();
        chk_all("sat", x, int'(cnt0), amax0, amin0, sk0, li0, le0);
      end
      if (q1.size() > 0) begin
        x = q1.pop_front();
        chk_all("wrap", x, int'(cnt1), amax1, amin1, sk1, li1, le1);
      end
      txn++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lv;
    bit r, ld, e, m;
    // Reset
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1);
    // Up across the forbidden value
    drive(1, 1, -16, 0, 0);
    repeat (3) drive(1, 0, 0, 1, 1);
    // Down across the forbidden value: 7, -2, -20
    drive(1, 1, 16, 0, 0);
    repeat (3) drive(1, 0, 0, 1, 0);
    // Upper limit
    drive(1, 1, 225, 0, 0);
    repeat (3) drive(1, 0, 0, 1, 1);
    // Lower limit
    drive(1, 1, -221, 0, 0);
    repeat (2) drive(1, 0, 0, 1, 0);
    // Load clamping and rejection
    drive(1, 1, 300, 0, 0);
    drive(1, 1, -11, 1, 1);
    drive(1, 1, 0, 0, 0);
    drive(1, 1, -300, 1, 0);
    drive(1, 1, 230, 0, 0);
    drive(1, 1, -230, 0, 0);
    // Reset overriding load and count, then hold
    repeat (3) drive(1, 0, 0, 1, 1);
    drive(0, 1, 100, 1, 1);
    repeat (5) drive(1, 0, 77, 0, 1);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 40) != 0);
      ld = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      m  = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: lv = int'($urandom_range(0, 1023)) - 512;
        1: lv = int'($urandom_range(0, 40)) - 31;
        2: lv = int'($urandom_range(0, 30)) + 210;
        default: lv = -int'($urandom_range(210, 240));
      endcase
      drive(r, ld, lv, e, m);
    end
    repeat (3) @(posedge clk);
    #2;
    chk("sat", "drained", q0.size(), 0);
    chk("wrap", "drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
